gtrom_flash_ctrl: RTL and testbench
===================================

# gtrom_flash_ctrl

Command sequencer for the in-system-writable PRG flash behind mapper 111 (GTROM). Decodes JEDEC/SST39SF040-style command sequences from CPU writes to $8000-$FFFF, issues byte-program, sector-erase and chip-erase operations to the memory backend over a req/ack handshake, and overrides CPU reads with emulated status and software-ID data while busy or in ID mode. It sits between the mapper's CPU bus decode and the PRG memory write path, replacing the bare 3-state unlock detector.

## Interface
Parameters:
- MAN_ID, 8'hBF, manufacturer ID returned at ID address 0
- DEV_ID, 8'hB7, device ID returned at ID address 1

Ports:
- clk  in  1  system clock; all state changes on rising edge
- map_rst  in  1  reset, synchronous, active-high
- wr_stb  in  1  one-cycle pulse per CPU write to $8000-$FFFF
- wr_addr  in  15  CPU address bits [14:0] of the write
- wr_dat  in  8  CPU write data
- bank  in  4  current PRG bank (mapper reg bits [3:0])
- rd_stb  in  1  one-cycle pulse per CPU read from $8000-$FFFF, issued after the read data is sampled
- rd_addr  in  15  CPU address bits [14:0] of the read
- ovr_oe  out  1  1 = CPU read data comes from ovr_dat instead of flash
- ovr_dat  out  8  override read data
- busy  out  1  operation in progress
- mem_req  out  1  backend request, held until acknowledged
- mem_op  out  2  0 = program, 1 = sector erase, 2 = chip erase
- mem_addr  out  19  backend byte/sector address
- mem_dat  out  8  program data (0xFF for erases)
- mem_ack  in  1  one-cycle completion pulse from the backend

## Operation
- States: IDLE, U1, U2, PGM, E1, E2, E3, ID, BUSY.
- Each wr_stb is evaluated in exactly one state. A mismatch returns to IDLE and is not re-evaluated as a new sequence start.
- IDLE: AA@5555 -> U1; anything else stays in IDLE (F0 anywhere included).
- U1: 55@2AAA -> U2.
- U2: A0@5555 -> PGM; 80@5555 -> E1; 90@5555 -> ID; F0@5555 -> IDLE.
- PGM: any write -> BUSY with mem_op=0, mem_addr={bank,wr_addr}, mem_dat=wr_dat. DQ7 latch = ~wr_dat[7].
- E1: AA@5555 -> E2. E2: 55@2AAA -> E3.
- E3: 30@any -> BUSY with op=1, mem_addr={bank,wr_addr[14:12],12'h000}. 10@5555 -> BUSY with op=2, mem_addr=0. In both cases mem_dat=FF and DQ7 latch=0.
- ID: a write of F0 at any address -> IDLE; all other writes are ignored and stay in ID.
- BUSY: all writes are ignored. mem_ack -> IDLE.
- ovr_oe = busy | (state==ID).
- ovr_dat while BUSY: {dq7, tgl, 6'b0}.
- ovr_dat in ID: rd_addr[0]==0 -> MAN_ID, else DEV_ID.
- tgl flips on every rd_stb while BUSY. It is not cleared on BUSY entry.
- mem_addr, mem_op and mem_dat stay stable for the whole time mem_req is high.

## Timing
- Reset values: state IDLE, busy=0, mem_req=0, mem_op=0, mem_addr=0, mem_dat=0, ovr_oe=0, tgl=0, dq7=0.
- State updates on the clk edge that samples wr_stb.
- mem_req and busy go high on the same edge that enters BUSY, i.e. 1 cycle after the final command strobe.
- mem_ack is honoured only while mem_req=1; stray acks are ignored. mem_req and busy fall on the edge that samples mem_ack.
- The minimum BUSY duration is 1 cycle, when ack arrives the cycle after req.
- ovr_oe and ovr_dat are functions of registered state. They are valid the cycle after the entering edge and remain valid through the last BUSY cycle.
- rd_stb together with mem_ack in the same cycle: tgl flips, then the block leaves BUSY.
- wr_stb together with mem_ack: the write is ignored.
- wr_stb and rd_stb in the same cycle: both are processed independently.
- map_rst asserted mid-BUSY: mem_req drops on that edge and all registers take their reset values. The backend must tolerate request withdrawal.

## Test plan
- Byte program: AA@5555, 55@2AAA, A0@5555, 3C@1234 with bank=5 -> mem_req=1, op=0, addr=0x29234, dat=0x3C. Two reads give ovr_dat=0x80 then 0xC0. Ack -> busy=0, ovr_oe=0.
- Sector erase: AA,55,80,AA,55 then 30@6ABC with bank=2 -> op=1, addr=0x16000, dat=FF. Reads give DQ7=0 with DQ6 toggling.
- Chip erase: five-cycle prefix then 10@5555 -> op=2, addr=0. A write of 10@1234 instead -> IDLE, no req.
- Abort paths: AA@5555, 56@2AAA -> IDLE. AA@5555 in U1 -> IDLE. A following valid full program sequence still works.
- ID mode: AA,55,90 -> reads at x000 give BF and at x001 give B7. Write 00@0 -> stays in ID. F0@0 -> IDLE, ovr_oe=0.
- Reset/ack edges: map_rst during BUSY -> mem_req=0, state IDLE next cycle. A stray mem_ack in IDLE has no effect. A write during BUSY does not change mem_addr or mem_dat.

Source files
------------

// File: rtl/gtrom_flash_ctrl.sv
// GTROM (mapper 111) PRG flash command sequencer: decodes SST39SF040-style
// unlock sequences, drives a req/ack memory backend and emulates status/ID reads.
module gtrom_flash_ctrl #(
  parameter logic [7:0] MAN_ID = 8'hBF,
  parameter logic [7:0] DEV_ID = 8'hB7
) (
  input  logic        clk,
  input  logic        map_rst,
  input  logic        wr_stb,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_dat,
  input  logic [3:0]  bank,
  input  logic        rd_stb,
  input  logic [14:0] rd_addr,
  output logic        ovr_oe,
  output logic [7:0]  ovr_dat,
  output logic        busy,
  output logic        mem_req,
  output logic [1:0]  mem_op,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_dat,
  input  logic        mem_ack
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_U1   = 4'd1,
    S_U2   = 4'd2,
    S_PGM  = 4'd3,
    S_E1   = 4'd4,
    S_E2   = 4'd5,
    S_E3   = 4'd6,
    S_ID   = 4'd7,
    S_BUSY = 4'd8
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [18:0] addr_q, addr_d;
  logic [7:0]  dat_q, dat_d;
  logic        dq7_q, dq7_d;
  logic        tgl_q, tgl_d;

  logic at_5555_s, at_2aaa_s, busy_s, id_s;
  logic unused_rd_addr_s;

  assign at_5555_s        = (wr_addr == 15'h5555);
  assign at_2aaa_s        = (wr_addr == 15'h2AAA);
  assign busy_s           = (state_q == S_BUSY);
  assign id_s             = (state_q == S_ID);
  assign unused_rd_addr_s = ^rd_addr[14:1];

  // State and operand registers
  always_ff @(posedge clk) begin
    if (map_rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      addr_q  <= 19'd0;
      dat_q   <= 8'd0;
      dq7_q   <= 1'b0;
      tgl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      dq7_q   <= dq7_d;
      tgl_q   <= tgl_d;
    end
  end

  // Command decode; every strobe is judged once, mismatches fall back to IDLE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    dq7_d   = dq7_q;
    tgl_d   = tgl_q ^ (rd_stb & busy_s);
    case (state_q)
      S_IDLE: begin
        if (wr_stb && wr_dat == 8'hAA && at_5555_s) state_d = S_U1;
        else                                          state_d = S_IDLE;
      end
      S_U1: begin
        if (wr_stb) state_d = (wr_dat == 8'h55 && at_2aaa_s) ? S_U2 : S_IDLE;
        else        state_d = S_U1;
      end
      S_U2: begin
        if (wr_stb && at_5555_s && wr_dat == 8'hA0)      state_d = S_PGM;
        else if (wr_stb && at_5555_s && wr_dat == 8'h80) state_d = S_E1;
        else if (wr_stb && at_5555_s && wr_dat == 8'h90) state_d = S_ID;
        else if (wr_stb)                                 state_d = S_IDLE;
        else                                             state_d = S_U2;
      end
      S_PGM: begin
        if (wr_stb) begin
          state_d = S_BUSY;
          op_d    = 2'd0;
          addr_d  = {bank, wr_addr};
          dat_d   = wr_dat;
          dq7_d   = ~wr_dat[7];
        end else begin
          state_d = S_PGM;
        end
      end
      S_E1: begin
        if (wr_stb) state_d = (wr_dat == 8'hAA && at_5555_s) ? S_E2 : S_IDLE;
        else        state_d = S_E1;
      end
      S_E2: begin
        if (wr_stb) state_d = (wr_dat == 8'h55 && at_2aaa_s) ? S_E3 : S_IDLE;
        else        state_d = S_E2;
      end
      S_E3: begin
        if (wr_stb && wr_dat == 8'h30) begin
          state_d = S_BUSY;
          op_d    = 2'd1;
          addr_d  = {bank, wr_addr[14:12], 12'h000};
          dat_d   = 8'hFF;
          dq7_d   = 1'b0;
        end else if (wr_stb && wr_dat == 8'h10 && at_5555_s) begin
          state_d = S_BUSY;
          op_d    = 2'd2;
          addr_d  = 19'd0;
          dat_d   = 8'hFF;
          dq7_d   = 1'b0;
        end else if (wr_stb) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_E3;
        end
      end
      S_ID: begin
        if (wr_stb && wr_dat == 8'hF0) state_d = S_IDLE;
        else                           state_d = S_ID;
      end
      S_BUSY: begin
        if (mem_ack) state_d = S_IDLE;
        else         state_d = S_BUSY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read override: status bits while busy, software ID while in ID mode
  always_comb begin
    ovr_dat = 8'h00;
    if (busy_s)    ovr_dat = {dq7_q, tgl_q, 6'b000000};
    else if (id_s) ovr_dat = rd_addr[0] ? DEV_ID : MAN_ID;
    else           ovr_dat = 8'h00;
  end

  assign ovr_oe   = busy_s | id_s;
  assign busy     = busy_s;
  assign mem_req  = busy_s;
  assign mem_op   = op_q;
  assign mem_addr = addr_q;
  assign mem_dat  = dat_q;

endmodule

// File: tb/tb_gtrom_flash_ctrl.sv
// Directed vector bench for gtrom_flash_ctrl: each row drives one cycle and
// checks the outputs seen during that cycle (before its rising edge).
module tb_gtrom_flash_ctrl;

  logic        clk = 1'b0;
  logic        map_rst, wr_stb, rd_stb, mem_ack;
  logic [14:0] wr_addr, rd_addr;
  logic [7:0]  wr_dat;
  logic [3:0]  bank;
  logic        ovr_oe, busy, mem_req;
  logic [7:0]  ovr_dat, mem_dat;
  logic [1:0]  mem_op;
  logic [18:0] mem_addr;

  gtrom_flash_ctrl dut (
    .clk(clk), .map_rst(map_rst), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_dat(wr_dat), .bank(bank), .rd_stb(rd_stb), .rd_addr(rd_addr),
    .ovr_oe(ovr_oe), .ovr_dat(ovr_dat), .busy(busy), .mem_req(mem_req),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_dat(mem_dat), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [14:0] wa;
    logic [7:0]  wd;
    logic [3:0]  bk;
    logic        rd;
    logic [14:0] ra;
    logic        ack;
    logic        rst;
    logic        e_busy;
    logic        e_oe;
    logic [7:0]  e_odat;
    logic        cm;
    logic [1:0]  e_op;
    logic [18:0] e_addr;
    logic [7:0]  e_dat;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   req_cycles = 0;
  bit   run_done = 1'b0;

  task automatic v(input logic wr, input logic [14:0] wa, input logic [7:0] wd,
                   input logic [3:0] bk, input logic rd, input logic [14:0] ra,
                   input logic ack, input logic rst, input logic e_busy,
                   input logic e_oe, input logic [7:0] e_odat, input logic cm,
                   input logic [1:0] e_op, input logic [18:0] e_addr,
                   input logic [7:0] e_dat);
    vec_t t;
    t.wr = wr; t.wa = wa; t.wd = wd; t.bk = bk; t.rd = rd; t.ra = ra;
    t.ack = ack; t.rst = rst; t.e_busy = e_busy; t.e_oe = e_oe;
    t.e_odat = e_odat; t.cm = cm; t.e_op = e_op; t.e_addr = e_addr; t.e_dat = e_dat;
    vecs.push_back(t);
  endtask

  // idle cycle expecting no activity
  task automatic nop;
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
      1'b0, 2'd0, 19'h0, 8'h00);
  endtask

  // write while not busy and not in ID
  task automatic w(input logic [7:0] d, input logic [14:0] a, input logic [3:0] bk);
    v(1'b1, a, d, bk, 1'b0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
      1'b0, 2'd0, 19'h0, 8'h00);
  endtask

  task automatic prefix5;
    w(8'hAA, 15'h5555, 4'h0); w(8'h55, 15'h2AAA, 4'h0); w(8'h80, 15'h5555, 4'h0);
    w(8'hAA, 15'h5555, 4'h0); w(8'h55, 15'h2AAA, 4'h0);
  endtask

  task automatic unlock(input logic [7:0] cmd);
    w(8'hAA, 15'h5555, 4'h0); w(8'h55, 15'h2AAA, 4'h0); w(cmd, 15'h5555, 4'h0);
  endtask

  // bounded request duration: mem_req must not stay high indefinitely
  always @(posedge clk) begin
    if (mem_req === 1'b1) req_cycles <= req_cycles + 1;
    else                  req_cycles <= 0;
    if (req_cycles > 16) begin
      n_fail++;
      $display("FAIL timeout: mem_req held high for %0d cycles", req_cycles);
      $finish;
    end
  end

  // global simulation time limit
  initial begin
    #100000;
    if (!run_done) begin
      n_fail++;
      $display("FAIL timeout: simulation did not complete in time");
      $finish;
    end
  end

  initial begin
    map_rst = 1'b1; wr_stb = 1'b0; rd_stb = 1'b0; mem_ack = 1'b0;
    wr_addr = 15'h0; rd_addr = 15'h0; wr_dat = 8'h00; bank = 4'h0;

    // reset values, then stray ack in IDLE
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 19'h0, 8'h00);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b0, 15'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 19'h0, 8'h00);
    // byte program 3C@1234 bank 5
    unlock(8'hA0); w(8'h3C, 15'h1234, 4'h5);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b1, 15'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 2'd0, 19'h29234, 8'h3C);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b1, 15'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC0, 1'b1, 2'd0, 19'h29234, 8'h3C);
    v(1'b1, 15'h0, 8'h77, 4'h0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 2'd0, 19'h29234, 8'h3C);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b0, 15'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 2'd0, 19'h29234, 8'h3C);
    nop;
    // sector erase 30@6ABC bank 2, ack one cycle after entry with a read
    prefix5; w(8'h30, 15'h6ABC, 4'h2);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b1, 15'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 2'd1, 19'h16000, 8'hFF);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b1, 15'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 2'd1, 19'h16000, 8'hFF);
    nop;
    // chip erase; read coincident with ack leaves tgl set
    prefix5; w(8'h10, 15'h5555, 4'h3);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b1, 15'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 2'd2, 19'h0, 8'hFF);
    nop;
    // chip erase command at wrong address aborts
    prefix5; w(8'h10, 15'h1234, 4'h0); nop;
    // abort paths, mismatched strobes not re-evaluated as sequence starts
    w(8'hAA, 15'h5555, 4'h0); w(8'h56, 15'h2AAA, 4'h0);
    w(8'hAA, 15'h5555, 4'h0); w(8'hAA, 15'h5555, 4'h0);
    w(8'h55, 15'h2AAA, 4'h0); w(8'hA0, 15'h5555, 4'h0); w(8'h3C, 15'h1234, 4'h0); nop;
    // valid program afterwards; tgl carries over (starts at 1)
    unlock(8'hA0); w(8'h81, 15'h7FFF, 4'hF);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b1, 15'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 2'd0, 19'h7FFFF, 8'h81);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 2'd0, 19'h7FFFF, 8'h81);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b0, 15'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 2'd0, 19'h7FFFF, 8'h81);
    nop;
    // software ID mode
    unlock(8'h90);
    v(1'b0, 15'h0,    8'h00, 4'h0, 1'b1, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBF, 1'b0, 2'd0, 19'h0, 8'h00);
    v(1'b0, 15'h0,    8'h00, 4'h0, 1'b1, 15'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB7, 1'b0, 2'd0, 19'h0, 8'h00);
    v(1'b0, 15'h0,    8'h00, 4'h0, 1'b1, 15'h4000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBF, 1'b0, 2'd0, 19'h0, 8'h00);
    v(1'b1, 15'h0,    8'h00, 4'h0, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBF, 1'b0, 2'd0, 19'h0, 8'h00);
    v(1'b1, 15'h5555, 8'hAA, 4'h0, 1'b0, 15'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB7, 1'b0, 2'd0, 19'h0, 8'h00);
    v(1'b1, 15'h0,    8'hF0, 4'h0, 1'b0, 15'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB7, 1'b0, 2'd0, 19'h0, 8'h00);
    nop;
    // F0 in U2 returns to IDLE
    unlock(8'hF0); nop;
    // reset during BUSY withdraws the request
    unlock(8'hA0); w(8'h12, 15'h0055, 4'h3);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 2'd0, 19'h18055, 8'h12);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b0, 15'h0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 2'd0, 19'h18055, 8'h12);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 19'h0, 8'h00);
    v(1'b0, 15'h0, 8'h00, 4'h0, 1'b0, 15'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 19'h0, 8'h00);
    nop;

    repeat (2) @(posedge clk);
    @(negedge clk);
    if (busy !== 1'b0 || mem_req !== 1'b0 || ovr_oe !== 1'b0 ||
        mem_op !== 2'd0 || mem_addr !== 19'h0 || mem_dat !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: busy=%b req=%b oe=%b op=%0d addr=%h dat=%h; want all zero",
               busy, mem_req, ovr_oe, mem_op, mem_addr, mem_dat);
    end
    foreach (vecs[i]) begin
      @(negedge clk);
      map_rst = vecs[i].rst;  wr_stb = vecs[i].wr;  wr_addr = vecs[i].wa;
      wr_dat  = vecs[i].wd;   bank   = vecs[i].bk;  rd_stb  = vecs[i].rd;
      rd_addr = vecs[i].ra;   mem_ack = vecs[i].ack;
      #1;
      n_vec++;
      if (busy !== vecs[i].e_busy || mem_req !== vecs[i].e_busy ||
          ovr_oe !== vecs[i].e_oe ||
          (vecs[i].e_oe && ovr_dat !== vecs[i].e_odat) ||
          (vecs[i].cm && (mem_op !== vecs[i].e_op || mem_addr !== vecs[i].e_addr ||
                          mem_dat !== vecs[i].e_dat))) begin
        n_fail++;
        $display("FAIL vec%0d: got busy=%b req=%b oe=%b odat=%h op=%0d addr=%h dat=%h; want busy=%b oe=%b odat=%h op=%0d addr=%h dat=%h (mem checked=%b)",
                 i, busy, mem_req, ovr_oe, ovr_dat, mem_op, mem_addr, mem_dat,
                 vecs[i].e_busy, vecs[i].e_oe, vecs[i].e_odat, vecs[i].e_op,
                 vecs[i].e_addr, vecs[i].e_dat, vecs[i].cm);
      end
    end
    @(negedge clk);
    run_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
